gate_sweep_controller: RTL and testbench
========================================

GATE_SWEEP_CONTROLLER -- requirements
Module: gate_sweep_controller

Interface
REQ-001 Parameter SETTLE_W, 4, width of the settle-cycle count.
REQ-002 Parameter NUM_VEC, 16, number of ABCD codes swept, fixed at 16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begins a sweep when sampled high in IDLE.
REQ-006 abort  input  1  terminates an active sweep.
REQ-007 settle_cycles  input  SETTLE_W  cycles to wait between applying a code and sampling F.
REQ-008 f_in  input  1  output F of the 4-input delay gate under control.
REQ-009 abcd  output  4  registered code driven to the gate.
REQ-010 busy  output  1  high in APPLY, SETTLE and SAMPLE.
REQ-011 sample_valid  output  1  one-cycle pulse per sampled vector.
REQ-012 vec_idx  output  4  index of the vector being processed.
REQ-013 f_sampled  output  1  f_in value captured in SAMPLE.
REQ-014 mismatch  output  1  qualified by sample_valid; f_sampled differs from expected.
REQ-015 mismatch_count  output  5  mismatches in current/last sweep.
REQ-016 done  output  1  level; high from sweep completion until next start or reset.
REQ-017 pass  output  1  valid while done; high iff mismatch_count == 0.

Function
REQ-018 FSM states IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-019 IDLE/DONE + start (abort low): latch settle_cycles (0 treated as 1), vec_idx=0, mismatch_count=0, done=0, next state APPLY.
REQ-020 APPLY: abcd=vec_idx registered on entry, one cycle, then SETTLE with timer loaded from latched count.
REQ-021 SETTLE: timer decrements each cycle; exactly N cycles in SETTLE, then SAMPLE.
REQ-022 SAMPLE: f_sampled=f_in, sample_valid=1 for this cycle, mismatch computed combinationally vs expected.
REQ-023 Expected F: 0 when abcd[1:0]==2'b11, else 1.
REQ-024 mismatch_count increments on each mismatch, saturates at 31.
REQ-025 SAMPLE with vec_idx<15: vec_idx+1, go APPLY; vec_idx==15: go DONE, done=1, no wrap to 0.
REQ-026 Per-vector latency N+2 cycles; full sweep 16*(N+2) cycles from first APPLY to DONE entry.
REQ-027 abcd holds its value through SETTLE and SAMPLE; changes only on APPLY entry.
REQ-028 start while busy is ignored; settle_cycles changes mid-sweep have no effect.
REQ-029 abort while busy: next state IDLE, abcd=0, done=0, mismatch_count retained, no sample_valid.
REQ-030 start and abort same cycle in IDLE/DONE: abort wins, remain/return IDLE.
REQ-031 abort in IDLE or DONE: go IDLE, clear done.

Reset
REQ-032 rst high: state IDLE, abcd=0, vec_idx=0, busy=0, sample_valid=0, f_sampled=0, mismatch=0, mismatch_count=0, done=0, pass=0, timer=0.
REQ-033 rst mid-sweep overrides start and abort; next cycle all outputs at reset values.

Structure
REQ-034 Package gate_sweep_pkg holds state enum, NUM_VEC, expected-F function.
REQ-035 Settle timer is a sub-module sweep_settle_timer (load, decrement, expire flag).
REQ-036 Gate itself is outside this block; bench connects it between abcd and f_in.

Verification
REQ-037 Reset, start, settle_cycles=3, correct gate model -> 16 sample_valid pulses 5 cycles apart, done after 80 cycles, mismatch_count=0, pass=1.
REQ-038 Gate model forced F=1 always -> mismatch on idx 3,7,11,15; mismatch_count=4, pass=0.
REQ-039 settle_cycles=0 -> behaves as 1; sample_valid pulses every 3 cycles, 48-cycle sweep.
REQ-040 abort at vec_idx=6 during SETTLE -> IDLE next cycle, abcd=0, done=0, no further sample_valid.
REQ-041 start asserted mid-sweep and start+abort in IDLE -> sweep unaffected; stays IDLE respectively.
REQ-042 rst at vec_idx=9 in SAMPLE -> all outputs at reset values next cycle; new start sweeps from idx 0.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared state encoding, sweep length and expected-F rule
package gate_sweep_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
  localparam int NUM_VEC = 16;
  function automatic logic exp_f(input logic [3:0] code);
    return code[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter flagging the last settle cycle
module sweep_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);
  logic [W-1:0] cnt;
  // count down from the loaded value; the cycle holding 1 is the last one
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  assign expire = cnt == W'(1);
endmodule

// File: rtl/gate_sweep_controller.sv
// gate_sweep_controller: sweeps all ABCD codes through a gate and checks F
module gate_sweep_controller
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_W = 4,
  parameter int NUM_VEC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                f_in,
  output logic [3:0]          abcd,
  output logic                busy,
  output logic                sample_valid,
  output logic [3:0]          vec_idx,
  output logic                f_sampled,
  output logic                mismatch,
  output logic [4:0]          mismatch_count,
  output logic                done,
  output logic                pass
);
  state_t state, nxt;
  logic [SETTLE_W-1:0] n_q;
  logic f_hold, expire, idle_like, go, last;
  assign idle_like = state == IDLE || state == DONE;
  assign go = idle_like && start && !abort;
  assign last = vec_idx == 4'(NUM_VEC - 1);
  assign busy = state == APPLY || state == SETTLE || state == SAMPLE;
  assign sample_valid = state == SAMPLE && !abort;
  assign f_sampled = state == SAMPLE ? f_in : f_hold;
  assign mismatch = sample_valid && (f_sampled != exp_f(abcd));
  assign done = state == DONE;
  assign pass = done && mismatch_count == 5'd0;
  sweep_settle_timer #(.W(SETTLE_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(state == APPLY),
    .load_val(n_q),
    .dec(state == SETTLE),
    .expire(expire)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state; abort always returns to IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = abort ? IDLE : start ? APPLY : state;
      APPLY:      nxt = abort ? IDLE : SETTLE;
      SETTLE:     nxt = abort ? IDLE : expire ? SAMPLE : SETTLE;
      SAMPLE:     nxt = abort ? IDLE : last ? DONE : APPLY;
      default:    nxt = IDLE;
    endcase
  end
  // sweep datapath: code/index advance, settle latch, mismatch tally
  always_ff @(posedge clk)
    if (rst) begin
      n_q <= '0;
      vec_idx <= '0;
      abcd <= '0;
      mismatch_count <= '0;
      f_hold <= 1'b0;
    end else begin
      if (go) begin
        n_q <= settle_cycles == '0 ? SETTLE_W'(1) : settle_cycles;
        vec_idx <= '0;
        abcd <= '0;
        mismatch_count <= '0;
      end else if (busy && abort) abcd <= '0;
      else if (state == SAMPLE && !last) begin
        vec_idx <= vec_idx + 4'd1;
        abcd <= vec_idx + 4'd1;
      end
      if (mismatch && mismatch_count != 5'd31) mismatch_count <= mismatch_count + 5'd1;
      if (state == SAMPLE) f_hold <= f_in;
    end
endmodule

// File: tb/tb_gate_sweep_controller.sv
// tb_gate_sweep_controller: table-driven sweeps with a sample scoreboard
module tb_gate_sweep_controller;
  logic clk = 0, rst = 1, start = 0, abort = 0, f_in;
  logic [3:0] settle_cycles = 0, abcd, vec_idx;
  logic busy, sample_valid, f_sampled, mismatch, done, pass;
  logic [4:0] mismatch_count;
  int fmode = 0, cyc = 0, tests = 0, failed = 0;

  typedef struct { int settle; int fmode; int midstart; int exp_cnt; int exp_pass; } sweep_t;
  typedef struct { int idx; int f; int mm; int t; } exp_t;
  exp_t q[$];
  sweep_t tbl[6];

  gate_sweep_controller dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .settle_cycles(settle_cycles),
    .f_in(f_in), .abcd(abcd), .busy(busy), .sample_valid(sample_valid), .vec_idx(vec_idx),
    .f_sampled(f_sampled), .mismatch(mismatch), .mismatch_count(mismatch_count),
    .done(done), .pass(pass)
  );

  // gate model: 1 = stuck at 1, 2 = stuck at 0, else a correct gate
  assign f_in = fmode == 1 ? 1'b1 : fmode == 2 ? 1'b0 : !(abcd[1] && abcd[0]);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_sweep(input sweep_t v);
    int ne, c0, k, f, ok;
    exp_t e;
    ne = v.settle == 0 ? 1 : v.settle;
    @(negedge clk);
    start = 1; abort = 0; settle_cycles = 4'(v.settle); fmode = v.fmode;
    for (int i = 0; i < 16; i++) begin
      ok = (i & 3) != 3;
      f = v.fmode == 1 ? 1 : v.fmode == 2 ? 0 : ok;
      e.idx = i; e.f = f; e.mm = (f != ok); e.t = i * (ne + 2) + ne + 1;
      q.push_back(e);
    end
    @(negedge clk);
    start = 0; c0 = cyc; k = 0;
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < 16 * (ne + 2) + 4 && !done; n++) begin
      @(negedge clk);
      start = 0; settle_cycles = 4'(v.settle);
      if (sample_valid) begin
        if (q.size() == 0) chk("extra_sample", 1, 0);
        else begin
          e = q.pop_front();
          chk("sample_idx", vec_idx, e.idx);
          chk("sample_abcd", abcd, e.idx);
          chk("f_sampled", f_sampled, e.f);
          chk("mismatch", mismatch, e.mm);
          chk("sample_time", cyc - c0, e.t);
        end
        if (v.midstart != 0 && k == 4) begin start = 1; settle_cycles = 4'd7; end
        k++;
      end
    end
    chk("done", done, 1);
    chk("sweep_len", cyc - c0, 16 * (ne + 2));
    chk("num_samples", k, 16);
    chk("mismatch_count", mismatch_count, v.exp_cnt);
    chk("pass", pass, v.exp_pass);
    chk("done_vec_idx", vec_idx, 15);
    chk("done_busy", busy, 0);
    q.delete();
  endtask

  task automatic wait_sample(input int idx);
    int hit = 0;
    for (int i = 0; i < 400 && hit == 0; i++) begin
      @(negedge clk);
      if (sample_valid && vec_idx == 4'(idx)) hit = 1;
    end
    chk("wait_sample_timeout", hit, 1);
  endtask

  initial begin
    int pulses;
    tbl[0] = '{settle: 3, fmode: 0, midstart: 0, exp_cnt: 0, exp_pass: 1};
    tbl[1] = '{settle: 3, fmode: 1, midstart: 0, exp_cnt: 4, exp_pass: 0};
    tbl[2] = '{settle: 0, fmode: 0, midstart: 0, exp_cnt: 0, exp_pass: 1};
    tbl[3] = '{settle: 1, fmode: 0, midstart: 1, exp_cnt: 0, exp_pass: 1};
    tbl[4] = '{settle: 2, fmode: 2, midstart: 0, exp_cnt: 12, exp_pass: 0};
    tbl[5] = '{settle: 15, fmode: 1, midstart: 1, exp_cnt: 4, exp_pass: 0};

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_abcd", abcd, 0); chk("rst_busy", busy, 0); chk("rst_valid", sample_valid, 0);
    chk("rst_idx", vec_idx, 0); chk("rst_fs", f_sampled, 0); chk("rst_mm", mismatch, 0);
    chk("rst_cnt", mismatch_count, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_done_clears", done, 0);
    chk("abort_done_pass", pass, 0);

    @(negedge clk);
    start = 1; settle_cycles = 4'd3; fmode = 1;
    @(negedge clk);
    start = 0;
    wait_sample(5);
    @(negedge clk);
    chk("apply6_abcd", abcd, 6);
    @(negedge clk);
    chk("settle6_busy", busy, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0); chk("abort_abcd", abcd, 0);
    chk("abort_done", done, 0); chk("abort_cnt_kept", mismatch_count, 1);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (sample_valid || busy) pulses++; end
    chk("abort_no_samples", pulses, 0);

    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (busy) pulses++; end
    chk("start_abort_idle", pulses, 0);

    @(negedge clk);
    start = 1; settle_cycles = 4'd2; fmode = 1;
    @(negedge clk);
    start = 0;
    wait_sample(9);
    rst = 1; start = 1; abort = 1;
    @(negedge clk);
    rst = 0; start = 0; abort = 0;
    chk("mid_rst_abcd", abcd, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_idx", vec_idx, 0); chk("mid_rst_fs", f_sampled, 0); chk("mid_rst_mm", mismatch, 0);
    chk("mid_rst_cnt", mismatch_count, 0); chk("mid_rst_done", done, 0); chk("mid_rst_pass", pass, 0);
    run_sweep(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
